// File: rtl/lane_seg_pkg.sv
// Shared types and elaboration-time helpers for the lane-segmentation datapath.
// Holds the constant-divisor reciprocal record used by the index-to-(row, col) converter.
package lane_seg_pkg;

    localparam int IDX_W   = 64;
    localparam int PROD_W  = 129;
    localparam int MAGIC_W = 66;
    localparam int ROW_W   = 55;
    localparam int COL_W   = 16;

    typedef struct packed {
        logic [MAGIC_W-1:0] magic;
        logic [7:0]         shift;
        logic [7:0]         l;
    } divmod_const_t;

    // Round-up reciprocal: with SHIFT = 64 + clog2(W), floor(2^SHIFT / W) + 1 keeps
    // the quotient exact over the whole 64-bit index range.
    function automatic divmod_const_t calc_divmod(input int img_w);
        divmod_const_t     dc;
        logic [PROD_W-1:0] num;
        int                l;
        l             = $clog2(img_w);
        num           = '0;
        num[IDX_W + l] = 1'b1;
        dc.magic      = MAGIC_W'(num / PROD_W'(img_w) + PROD_W'(1));
        dc.shift      = 8'(IDX_W + l);
        dc.l          = 8'(l);
        return dc;
    endfunction

endpackage

// File: rtl/lane_seg_top_mul_64ns_66ns_129_1_1.sv
// Unsigned 64 x 66 -> 129 bit multiplier shared across the lane-segmentation datapath.
// Purely combinational; the caller registers the product.
module lane_seg_top_mul_64ns_66ns_129_1_1
    import lane_seg_pkg::*;
(
    input  logic [IDX_W-1:0]   din0,
    input  logic [MAGIC_W-1:0] din1,
    output logic [PROD_W-1:0]  dout
);

    assign dout = PROD_W'(din0) * PROD_W'(din1);

endmodule

// File: rtl/lane_seg_idx2rc.sv
// Three-stage flat pixel index to (row, col) converter using a reciprocal multiply.
// A single global enable stalls every stage together when the output is held.
module lane_seg_idx2rc
    import lane_seg_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int TAG_W = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IDX_W-1:0] s_idx,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ROW_W-1:0] m_row,
    output logic [COL_W-1:0] m_col,
    output logic             m_oob,
    output logic [TAG_W-1:0] m_tag,
    output logic [31:0]      done_cnt
);

    localparam divmod_const_t      DC      = calc_divmod(IMG_W);
    localparam int                 SHIFT   = int'(DC.shift);
    localparam logic [MAGIC_W-1:0] MAGIC   = DC.magic;
    localparam logic [IDX_W-1:0]   W64     = IDX_W'(IMG_W);
    localparam logic [IDX_W-1:0]   PIX_CNT = IDX_W'(IMG_W) * IDX_W'(IMG_H);

    function automatic logic [ROW_W-1:0] row_of(input logic [PROD_W-1:0] p);
        return ROW_W'(p >> SHIFT);
    endfunction

    // Remainder uses the full-width quotient so narrow images still get a correct column.
    function automatic logic [COL_W-1:0] col_of(input logic [IDX_W-1:0]  idx,
                                                input logic [PROD_W-1:0] p);
        return COL_W'(idx - IDX_W'(p >> SHIFT) * W64);
    endfunction

    logic              en;
    logic              vld_p0, vld_p1, vld_p2;
    logic [IDX_W-1:0]  idx_p0, idx_p1;
    logic [TAG_W-1:0]  tag_p0, tag_p1;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_p1;
    logic [ROW_W-1:0]  row_p2;
    logic [COL_W-1:0]  col_p2;
    logic              oob_p2;
    logic [TAG_W-1:0]  tag_p2;
    logic [31:0]       cnt;

    assign en      = !vld_p2 || m_ready;
    assign s_ready = en;

    lane_seg_top_mul_64ns_66ns_129_1_1 u_mul (
        .din0 (idx_p0),
        .din1 (MAGIC),
        .dout (prod)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            cnt    <= '0;
        end else begin
            if (vld_p2 && m_ready) begin
                cnt <= cnt + 32'd1;
            end
            if (en) begin
                vld_p0 <= s_valid;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
            end
        end
    end

    // S0 capture and S1 product register
    always_ff @(posedge ap_clk) begin
        if (en) begin
            idx_p0  <= s_idx;
            tag_p0  <= s_tag;
            prod_p1 <= prod;
            idx_p1  <= idx_p0;
            tag_p1  <= tag_p0;
        end
    end

    // S2 result register, cleared so the outputs read zero after reset
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            row_p2 <= '0;
            col_p2 <= '0;
            oob_p2 <= 1'b0;
            tag_p2 <= '0;
        end else if (en) begin
            row_p2 <= row_of(prod_p1);
            col_p2 <= col_of(idx_p1, prod_p1);
            oob_p2 <= (idx_p1 >= PIX_CNT);
            tag_p2 <= tag_p1;
        end
    end

    assign m_valid  = vld_p2;
    assign m_row    = row_p2;
    assign m_col    = col_p2;
    assign m_oob    = oob_p2;
    assign m_tag    = tag_p2;
    assign done_cnt = cnt;

endmodule

// File: tb/tb_lane_seg_idx2rc.sv
// Directed and randomized bench for lane_seg_idx2rc against a divide/modulo reference.
module tb_lane_seg_idx2rc;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int TAG_W = 8;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic             s_valid;
    logic             s_ready;
    logic [63:0]      s_idx;
    logic [TAG_W-1:0] s_tag;
    logic             m_valid;
    logic             m_ready;
    logic [54:0]      m_row;
    logic [15:0]      m_col;
    logic             m_oob;
    logic [TAG_W-1:0] m_tag;
    logic [31:0]      done_cnt;

    always #5 ap_clk = ~ap_clk;

    lane_seg_idx2rc #(.IMG_W(IMG_W), .IMG_H(IMG_H), .TAG_W(TAG_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_idx    (s_idx),
        .s_tag    (s_tag),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_row    (m_row),
        .m_col    (m_col),
        .m_oob    (m_oob),
        .m_tag    (m_tag),
        .done_cnt (done_cnt)
    );

    typedef struct {
        logic [63:0]      row;
        logic [63:0]      col;
        logic             oob;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n_acc   = 0;
    bit   chk_lat = 1'b0;
    bit   nxt_set = 1'b0;
    exp_t nxt;
    exp_t q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [63:0] idx, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.row = idx / 64'(IMG_W);
        e.col = idx % 64'(IMG_W);
        e.oob = (idx >= 64'(IMG_W) * 64'(IMG_H));
        e.tag = tag;
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [63:0] rnd_idx();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0:       v = {$urandom, $urandom};
            1:       v = 64'($urandom_range(0, IMG_W * IMG_H + IMG_W));
            2:       v = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5000));
            default: v = {32'h0, $urandom};
        endcase
        return v;
    endfunction

    task automatic drive(input bit v, input logic [63:0] idx, input logic [TAG_W-1:0] tag,
                         input bit rdy);
        s_valid = v;
        s_idx   = idx;
        s_tag   = tag;
        m_ready = rdy;
        #1;
    endtask

    // Score the handshakes about to happen on the coming edge, then advance one cycle.
    task automatic settle();
        exp_t e;
        if (m_valid && m_ready) begin
            check("output_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("row", 64'(m_row), e.row);
                check("col", 64'(m_col), e.col);
                check("oob", 64'(m_oob), 64'(e.oob));
                check("tag", 64'(m_tag), 64'(e.tag));
                if (chk_lat) check("latency", 64'(cyc - e.acc), 64'd3);
            end
        end
        if (s_valid && s_ready) begin
            e       = nxt_set ? nxt : model(s_idx, s_tag);
            e.acc   = cyc;
            nxt_set = 1'b0;
            q.push_back(e);
            n_acc++;
        end
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    task automatic send_exp(input logic [63:0] idx, input logic [TAG_W-1:0] tag,
                            input logic [63:0] row, input logic [63:0] col, input logic oob);
        nxt     = '{row: row, col: col, oob: oob, tag: tag, acc: 0};
        nxt_set = 1'b1;
        drive(1'b1, idx, tag, 1'b1);
        settle();
    endtask

    task automatic send_rnd();
        drive(1'b1, rnd_idx(), 8'($urandom), 1'b1);
        settle();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(1'b0, 64'd0, '0, 1'b1);
            settle();
        end
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        drive(1'b0, 64'd0, '0, 1'b0);
        @(posedge ap_clk);
        #1;
        cyc++;
        q.delete();
        nxt_set = 1'b0;
    endtask

    initial begin
        int budget;

        // Reset state, checked while reset is still asserted
        do_reset();
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_done_cnt", 64'(done_cnt), 64'd0);
        check("rst_m_row", 64'(m_row), 64'd0);
        check("rst_m_col", 64'(m_col), 64'd0);
        check("rst_m_oob", 64'(m_oob), 64'd0);
        check("rst_m_tag", 64'(m_tag), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        ap_rst = 1'b0;
        idle(3);
        check("idle_m_valid", 64'(m_valid), 64'd0);
        check("idle_s_ready", 64'(s_ready), 64'd1);
        check("idle_done_cnt", 64'(done_cnt), 64'd0);

        // Directed corner indices with exact latency
        chk_lat = 1'b1;
        send_exp(64'd0,      8'h11, 64'd0,   64'd0,   1'b0);
        send_exp(64'd639,    8'h22, 64'd0,   64'd639, 1'b0);
        send_exp(64'd640,    8'h33, 64'd1,   64'd0,   1'b0);
        send_exp(64'd307199, 8'h44, 64'd479, 64'd639, 1'b0);
        send_exp(64'd307200, 8'h55, 64'd480, 64'd0,   1'b1);
        send_exp(64'hFFFF_FFFF_FFFF_FFFF, 8'h66, 64'd28823037615171174, 64'd255, 1'b1);
        idle(5);
        check("directed_drained", 64'(q.size()), 64'd0);
        check("directed_done_cnt", 64'(done_cnt), 64'd6);

        // Stall hold with a full pipeline
        send_rnd();
        send_rnd();
        send_rnd();
        chk_lat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rnd_idx(), 8'($urandom), 1'b0);
            check("stall_s_ready", 64'(s_ready), 64'd0);
            check("stall_m_valid", 64'(m_valid), 64'd1);
            check("stall_row", 64'(m_row), q[0].row);
            check("stall_col", 64'(m_col), q[0].col);
            check("stall_tag", 64'(m_tag), 64'(q[0].tag));
            check("stall_done_cnt", 64'(done_cnt), 64'd6);
            settle();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'd0, '0, 1'b1);
            check("drain_m_valid", 64'(m_valid), 64'd1);
            settle();
        end
        drive(1'b0, 64'd0, '0, 1'b1);
        check("drain_empty", 64'(m_valid), 64'd0);
        settle();
        check("stall_done_total", 64'(done_cnt), 64'd9);

        // Reset with three items in flight
        chk_lat = 1'b1;
        send_rnd();
        send_rnd();
        send_rnd();
        do_reset();
        ap_rst = 1'b0;
        check("midrst_m_valid", 64'(m_valid), 64'd0);
        check("midrst_done_cnt", 64'(done_cnt), 64'd0);
        idle(4);
        check("midrst_no_stale", 64'(done_cnt), 64'd0);
        send_rnd();
        idle(4);
        check("midrst_drained", 64'(q.size()), 64'd0);
        check("midrst_done_one", 64'(done_cnt), 64'd1);

        // Randomized traffic with 50% backpressure
        do_reset();
        ap_rst  = 1'b0;
        chk_lat = 1'b0;
        n_acc   = 0;
        budget  = 0;
        while (n_acc < 10000 && budget < 60000) begin
            drive($urandom_range(0, 3) != 0, rnd_idx(), 8'($urandom), 1'($urandom_range(0, 1)));
            settle();
            budget++;
        end
        check("random_budget", 64'(n_acc >= 10000), 64'd1);
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            drive(1'b0, 64'd0, '0, 1'b1);
            settle();
        end
        check("random_drained", 64'(q.size()), 64'd0);
        check("random_done_cnt", 64'(done_cnt), 64'd10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
